fpu_add_sub_pipe: RTL and testbench



---
 rtl/fpu_add_sub_pipe.sv | 185 ++++++++++++++++++
 tb/tb_fpu_add_sub_pipe.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fpu_add_sub_pipe.sv
// fpu_add_sub_pipe: 3-stage IEEE-754 adder/subtractor (align, add, normalise+round)
// Ports: clk_i/reset_i (sync, active-high), flush_i drops in-flight ops;
//   in_valid_i/in_ready_o + a_i, b_i, sub_i, rm_i, tag_i accept an operation;
//   out_valid_o/out_ready_i + result_o, tag_o, flags_o {NV,DZ,OF,UF,NX} deliver it.
// Build option: define FPU_ADD_SUB_FTZ_EN to flush subnormal inputs and results to zero.
module fpu_add_sub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [EXP_W+MAN_W:0]   a_i,
  input  logic [EXP_W+MAN_W:0]   b_i,
  input  logic                   sub_i,
  input  logic [2:0]             rm_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [EXP_W+MAN_W:0]   result_o,
  output logic [TAG_W-1:0]       tag_o,
  output logic [4:0]             flags_o
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int F = MAN_W + 4;
  localparam int X = EXP_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {MAN_W-1{1'b0}}};
  function automatic int lzc(input logic [F-1:0] v);
    lzc = F;
    for (int i = 0; i < F; i++) if (v[i]) lzc = F - 1 - i;
  endfunction
  logic adv;
  logic v1_q, v2_q, out_valid_q;
  logic sp1_q, sp2_q, nv1_q, nv2_q, s1_q, s2_q, sub1_q;
  logic [W-1:0] spr1_q, spr2_q, result_q;
  logic [EXP_W-1:0] e1_q, e2_q;
  logic [MAN_W:0] ml1_q;
  logic [F-1:0] ms1_q;
  logic [F:0] sum2_q;
  logic [2:0] rm1_q, rm2_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag_q;
  logic [4:0] flags_q;
  assign adv = !out_valid_q || out_ready_i;
  assign in_ready_o = adv;
  assign out_valid_o = out_valid_q;
  assign result_o = result_q;
  assign tag_o = tag_q;
  assign flags_o = flags_q;
  logic [EXP_W-1:0] xa, xb, ea, eb, el, es, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0] ma, mb, ml, ms;
  logic [F-1:0] full, shf, al_d;
  logic [2:0] rm_d;
  logic sa, sb, sl, ss, za, zb, ia, ib, na, nb, inv_d, abig, sp_d;
  logic [W-1:0] spr_d;
  always_comb begin
    {xa, fa} = a_i[W-2:0];
    {xb, fb} = b_i[W-2:0];
    sa = a_i[W-1];
    sb = b_i[W-1] ^ sub_i;
`ifdef FPU_ADD_SUB_FTZ_EN
    za = xa == '0;
    zb = xb == '0;
`else
    za = xa == '0 && fa == '0;
    zb = xb == '0 && fb == '0;
`endif
    ia = xa == EMAX && fa == '0;
    ib = xb == EMAX && fb == '0;
    na = xa == EMAX && fa != '0;
    nb = xb == EMAX && fb != '0;
    ea = xa == '0 ? EXP_W'(1) : xa;
    eb = xb == '0 ? EXP_W'(1) : xb;
    ma = {xa != '0, fa};
    mb = {xb != '0, fb};
    abig = {ea, ma} >= {eb, mb};
    {el, ml, sl} = abig ? {ea, ma, sa} : {eb, mb, sb};
    {es, ms, ss} = abig ? {eb, mb, sb} : {ea, ma, sa};
    diff = el - es;
    full = {ms, 3'b000};
    shf = full >> diff;
    // every bit shifted past the field collapses into the sticky position
    al_d = {shf[F-1:1], shf[0] | (|(full & ~({F{1'b1}} << diff)))};
    rm_d = rm_i > RMM ? RNE : rm_i;
    inv_d = (na && !fa[MAN_W-1]) || (nb && !fb[MAN_W-1]) || (ia && ib && sa != sb);
    sp_d = na || nb || ia || ib || za || zb;
    spr_d = (na || nb || inv_d) ? QNAN :
            ia ? {sa, EMAX, {MAN_W{1'b0}}} :
            ib ? {sb, EMAX, {MAN_W{1'b0}}} :
            (za && zb) ? {(sa == sb) ? sa : (rm_d == RDN), {W-1{1'b0}}} :
            za ? {sb, b_i[W-2:0]} : a_i;
  end
  logic [F:0] sum_d;
  assign sum_d = sub1_q ? {1'b0, ml1_q, 3'b000} - {1'b0, ms1_q} : {1'b0, ml1_q, 3'b000} + {1'b0, ms1_q};
  int lz, sh;
  logic [X-1:0] e, er;
  logic [F-1:0] nm;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] frac;
  logic up, nx, hid, of, tomax;
  logic [W-1:0] res_d;
  logic [4:0] fl_d;
  always_comb begin
    lz = lzc(sum2_q[F-1:0]);
    // left shift stops at exponent 1 so tiny results come out subnormal
    sh = (lz > int'(e2_q) - 1) ? int'(e2_q) - 1 : lz;
    nm = sum2_q[F] ? {sum2_q[F:2], |sum2_q[1:0]} : sum2_q[F-1:0] << sh;
    e = sum2_q[F] ? {2'b00, e2_q} + X'(1) : {2'b00, e2_q} - X'(sh);
    nx = |nm[2:0];
    up = rm2_q == RNE ? nm[2] && (nm[1] || nm[0] || nm[3]) :
         rm2_q == RTZ ? 1'b0 :
         rm2_q == RDN ? s2_q && nx :
         rm2_q == RUP ? !s2_q && nx : nm[2];
    mr = {1'b0, nm[F-1:3]} + {{MAN_W+1{1'b0}}, up};
    er = mr[MAN_W+1] ? e + X'(1) : e;
    frac = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
    hid = mr[MAN_W+1] || mr[MAN_W];
    of = er >= {2'b00, EMAX};
    tomax = rm2_q == RTZ || (rm2_q == RDN && !s2_q) || (rm2_q == RUP && s2_q);
    res_d = {s2_q, hid ? er[EXP_W-1:0] : {EXP_W{1'b0}}, frac};
    fl_d = {3'b000, !hid && nx, nx};
`ifdef FPU_ADD_SUB_FTZ_EN
    if (!hid) begin
      res_d = {s2_q, {W-1{1'b0}}};
      fl_d = 5'b00011;
    end
`endif
    if (of) begin
      res_d = tomax ? {s2_q, EMAX - EXP_W'(1), {MAN_W{1'b1}}} : {s2_q, EMAX, {MAN_W{1'b0}}};
      fl_d = 5'b00101;
    end
    if (sum2_q == '0) begin
      res_d = {rm2_q == RDN, {W-1{1'b0}}};
      fl_d = 5'b00000;
    end
    if (sp2_q) begin
      res_d = spr2_q;
      fl_d = {nv2_q, 4'b0000};
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      out_valid_q <= 1'b0;
      result_q <= '0;
      tag_q <= '0;
      flags_q <= '0;
    end else if (flush_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid_i;
      sp1_q <= sp_d;
      spr1_q <= spr_d;
      nv1_q <= inv_d;
      s1_q <= sl;
      sub1_q <= sl != ss;
      e1_q <= el;
      ml1_q <= ml;
      ms1_q <= al_d;
      rm1_q <= rm_d;
      tag1_q <= tag_i;
      v2_q <= v1_q;
      sp2_q <= sp1_q;
      spr2_q <= spr1_q;
      nv2_q <= nv1_q;
      s2_q <= s1_q;
      e2_q <= e1_q;
      sum2_q <= sum_d;
      rm2_q <= rm1_q;
      tag2_q <= tag1_q;
      out_valid_q <= v2_q;
      result_q <= res_d;
      tag_q <= tag2_q;
      flags_q <= fl_d;
    end
  end
endmodule

// File: tb/tb_fpu_add_sub_pipe.sv
// tb_fpu_add_sub_pipe: directed self-checking bench for fpu_add_sub_pipe (binary32 defaults)
// Expectations follow FPU_ADD_SUB_FTZ_EN when the bench is built with it defined.
module tb_fpu_add_sub_pipe;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic flush_i = 1'b0;
  logic in_valid_i = 1'b0;
  logic in_ready_o;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic sub_i = 1'b0;
  logic [2:0] rm_i = 3'd0;
  logic [4:0] tag_i = '0;
  logic out_valid_o;
  logic out_ready_i = 1'b1;
  logic [31:0] result_o;
  logic [4:0] tag_o;
  logic [4:0] flags_o;
  int n_chk = 0;
  int n_fail = 0;
  fpu_add_sub_pipe dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .sub_i(sub_i), .rm_i(rm_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .tag_o(tag_o), .flags_o(flags_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, got, want);
    end
  endtask
  task automatic op(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic [2:0] rm, input logic [31:0] er, input logic [4:0] ef);
    int n;
    a_i = a;
    b_i = b;
    sub_i = s;
    rm_i = rm;
    tag_i = 5'd7;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    n = 1;
    while (!out_valid_o && n < 10) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(3));
    chk({nm, " result"}, 64'(result_o), 64'(er));
    chk({nm, " flags"}, 64'(flags_o), 64'(ef));
    chk({nm, " tag"}, 64'(tag_o), 64'(7));
    @(posedge clk_i);
    #1;
  endtask
  logic [31:0] st_a [6] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
  logic [31:0] st_r [6] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
  initial begin
    int sent, got, seen;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    chk("reset out_valid", 64'(out_valid_o), 64'(0));
    chk("reset result", 64'(result_o), 64'(0));
    chk("reset tag", 64'(tag_o), 64'(0));
    chk("reset flags", 64'(flags_o), 64'(0));
    chk("reset in_ready", 64'(in_ready_o), 64'(1));
    op("1+2", 32'h3F800000, 32'h40000000, 1'b0, 3'd0, 32'h40400000, 5'b00000);
    op("1-1 rne", 32'h3F800000, 32'h3F800000, 1'b1, 3'd0, 32'h00000000, 5'b00000);
    op("1-1 rdn", 32'h3F800000, 32'h3F800000, 1'b1, 3'd2, 32'h80000000, 5'b00000);
    op("inf-inf", 32'h7F800000, 32'h7F800000, 1'b1, 3'd0, 32'h7FC00000, 5'b10000);
    op("snan+1", 32'h7F800001, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 5'b10000);
    op("inf+1", 32'hFF800000, 32'h3F800000, 1'b0, 3'd0, 32'hFF800000, 5'b00000);
    op("max+max rne", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 32'h7F800000, 5'b00101);
    op("max+max rtz", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd1, 32'h7F7FFFFF, 5'b00101);
    op("max+max rdn", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd2, 32'h7F7FFFFF, 5'b00101);
    op("-max-max rdn", 32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd2, 32'hFF800000, 5'b00101);
    op("tie rne", 32'h3F800000, 32'h33800000, 1'b0, 3'd0, 32'h3F800000, 5'b00001);
    op("tie rup", 32'h3F800000, 32'h33800000, 1'b0, 3'd3, 32'h3F800001, 5'b00001);
    op("tie rmm", 32'h3F800000, 32'h33800000, 1'b0, 3'd4, 32'h3F800001, 5'b00001);
    op("tie rm5", 32'h3F800000, 32'h33800000, 1'b0, 3'd5, 32'h3F800000, 5'b00001);
    op("0-2", 32'h00000000, 32'h40000000, 1'b1, 3'd0, 32'hC0000000, 5'b00000);
    op("-0+-0", 32'h80000000, 32'h80000000, 1'b0, 3'd0, 32'h80000000, 5'b00000);
    op("3-1", 32'h40400000, 32'h3F800000, 1'b1, 3'd0, 32'h40000000, 5'b00000);
`ifdef FPU_ADD_SUB_FTZ_EN
    op("sub+sub", 32'h00000001, 32'h00000001, 1'b0, 3'd0, 32'h00000000, 5'b00000);
`else
    op("sub+sub", 32'h00000001, 32'h00000001, 1'b0, 3'd0, 32'h00000002, 5'b00000);
`endif
    sent = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      in_valid_i = sent < 6;
      a_i = st_a[sent < 6 ? sent : 5];
      b_i = 32'h3F800000;
      sub_i = 1'b0;
      rm_i = 3'd0;
      tag_i = 5'(sent);
      out_ready_i = !(c >= 4 && c <= 7);
      @(negedge clk_i);
      if (c >= 4 && c <= 7) begin
        chk("stall in_ready", 64'(in_ready_o), 64'(0));
        chk("stall out_valid", 64'(out_valid_o), 64'(1));
        chk("stall result", 64'(result_o), 64'(st_r[1]));
        chk("stall tag", 64'(tag_o), 64'(1));
      end
      if (out_valid_o && out_ready_i) begin
        chk("stream result", 64'(result_o), 64'(st_r[got]));
        chk("stream tag", 64'(tag_o), 64'(got));
        got++;
      end
      if (in_valid_i && in_ready_o) sent++;
      @(posedge clk_i);
      #1;
    end
    chk("stream count", 64'(got), 64'(6));
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    a_i = 32'h3F800000;
    b_i = 32'h3F800000;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    seen = 0;
    repeat (8) begin
      if (out_valid_o) seen++;
      @(posedge clk_i);
      #1;
    end
    chk("flush drained", 64'(seen), 64'(0));
    op("after flush", 32'h3F800000, 32'h40000000, 1'b0, 3'd0, 32'h40400000, 5'b00000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
